// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared constants and FSM state types for the UART echo design
package uart_pkg;

    localparam int CLKS_PER_BIT_DEF = 2604;
    localparam int HALF_BIT_DEF     = CLKS_PER_BIT_DEF / 2;
    localparam int DATA_BITS        = 8;
    localparam int BIT_IDX_W        = 3;
    localparam int CNT_W            = 16;

    // Clocks of delay through the receive synchronizer; the receiver shortens
    // its end-of-stop wait by this much so the echo lines up with the bit grid.
    localparam int SYNC_LAT         = 2;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP,
        RX_DONE
    } rx_state_e;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_STOP
    } tx_state_e;

endpackage

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 receiver with input synchronizer and framing flag
// Ports: clk_i/rst_ni clock and async active-low reset; rx_i raw serial line;
//        data_o received byte; valid_o one-cycle byte strobe; busy_o FSM not idle;
//        frame_err_o set by a bad stop bit, cleared by the next good frame.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 rx_i,
    output logic [DATA_BITS-1:0] data_o,
    output logic                 valid_o,
    output logic                 busy_o,
    output logic                 frame_err_o
);
    localparam int HALF_BIT = CLKS_PER_BIT / 2;
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_BIT - 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] DONE_LAST = CNT_W'(HALF_BIT - SYNC_LAT - 1);

    rx_state_e              state_q;
    logic                   meta_q;
    logic                   sync_q;
    logic                   prev_q;
    logic [CNT_W-1:0]       cnt_q;
    logic [BIT_IDX_W-1:0]   bit_q;
    logic [DATA_BITS-1:0]   shift_q;
    logic                   valid_q;
    logic                   err_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            meta_q  <= 1'b1;
            sync_q  <= 1'b1;
            prev_q  <= 1'b1;
            state_q <= RX_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            meta_q  <= rx_i;
            sync_q  <= meta_q;
            prev_q  <= sync_q;
            valid_q <= 1'b0;
            cnt_q   <= cnt_q + 1'b1;
            case (state_q)
                RX_IDLE: begin
                    cnt_q <= '0;
                    // Edge, not level: after a framing error the line may still be low.
                    if (prev_q && !sync_q) begin
                        state_q <= RX_START;
                    end
                end
                RX_START: begin
                    if (cnt_q == HALF_LAST) begin
                        cnt_q   <= '0;
                        bit_q   <= '0;
                        state_q <= sync_q ? RX_IDLE : RX_DATA;
                    end
                end
                RX_DATA: begin
                    if (cnt_q == BIT_LAST) begin
                        cnt_q   <= '0;
                        shift_q <= {sync_q, shift_q[DATA_BITS-1:1]};
                        bit_q   <= bit_q + 1'b1;
                        if (bit_q == BIT_IDX_W'(DATA_BITS - 1)) begin
                            state_q <= RX_STOP;
                        end
                    end
                end
                RX_STOP: begin
                    if (cnt_q == BIT_LAST) begin
                        cnt_q <= '0;
                        if (sync_q) begin
                            state_q <= RX_DONE;
                        end else begin
                            err_q   <= 1'b1;
                            state_q <= RX_IDLE;
                        end
                    end
                end
                RX_DONE: begin
                    if (cnt_q == DONE_LAST) begin
                        valid_q <= 1'b1;
                        err_q   <= 1'b0;
                        state_q <= RX_IDLE;
                    end
                end
                default: state_q <= RX_IDLE;
            endcase
        end
    end

    assign data_o      = shift_q;
    assign valid_o     = valid_q;
    assign busy_o      = (state_q != RX_IDLE);
    assign frame_err_o = err_q;

endmodule

// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - 8N1 transmitter with registered line output
// Ports: clk_i/rst_ni clock and async active-low reset; start_i accept data_i
//        when idle; tx_o serial line (idles high); busy_o high from start bit
//        through the last stop-bit clock.
module uart_tx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 start_i,
    input  logic [DATA_BITS-1:0] data_i,
    output logic                 tx_o,
    output logic                 busy_o
);
    localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    tx_state_e              state_q;
    logic [CNT_W-1:0]       cnt_q;
    logic [BIT_IDX_W-1:0]   bit_q;
    logic [DATA_BITS-1:0]   shift_q;
    logic                   tx_q;
    logic                   busy_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= TX_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
        end else begin
            cnt_q <= cnt_q + 1'b1;
            case (state_q)
                TX_IDLE: begin
                    cnt_q <= '0;
                    if (start_i) begin
                        shift_q <= data_i;
                        tx_q    <= 1'b0;
                        busy_q  <= 1'b1;
                        state_q <= TX_START;
                    end
                end
                TX_START: begin
                    if (cnt_q == BIT_LAST) begin
                        cnt_q   <= '0;
                        bit_q   <= '0;
                        tx_q    <= shift_q[0];
                        shift_q <= {1'b0, shift_q[DATA_BITS-1:1]};
                        state_q <= TX_DATA;
                    end
                end
                TX_DATA: begin
                    if (cnt_q == BIT_LAST) begin
                        cnt_q <= '0;
                        bit_q <= bit_q + 1'b1;
                        if (bit_q == BIT_IDX_W'(DATA_BITS - 1)) begin
                            tx_q    <= 1'b1;
                            state_q <= TX_STOP;
                        end else begin
                            tx_q    <= shift_q[0];
                            shift_q <= {1'b0, shift_q[DATA_BITS-1:1]};
                        end
                    end
                end
                TX_STOP: begin
                    if (cnt_q == BIT_LAST) begin
                        busy_q  <= 1'b0;
                        state_q <= TX_IDLE;
                    end
                end
                default: state_q <= TX_IDLE;
            endcase
        end
    end

    assign tx_o   = tx_q;
    assign busy_o = busy_q;

endmodule

// File: rtl/uart_echo_top.sv
// rtl/uart_echo_top.sv - UART loopback: echoes each good 8N1 byte, drives status LEDs
// Ports: CLK clock; RST_N async active-low reset; U_RX serial in; U_TX serial out;
//        RED_N receiver busy; GREEN_N transmitter busy; BLUE_N framing error (all active-low).
module uart_echo_top
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
    input  logic CLK,
    input  logic RST_N,
    input  logic U_RX,
    output logic U_TX,
    output logic RED_N,
    output logic GREEN_N,
    output logic BLUE_N
);
    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_valid;
    logic                 rx_busy;
    logic                 frame_err;
    logic                 waitflg;
    logic                 tx_start;
    logic [DATA_BITS-1:0] hold_q;
    logic                 hold_full_q;

    uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
        .clk_i       (CLK),
        .rst_ni      (RST_N),
        .rx_i        (U_RX),
        .data_o      (rx_data),
        .valid_o     (rx_valid),
        .busy_o      (rx_busy),
        .frame_err_o (frame_err)
    );

    assign tx_start = hold_full_q && !waitflg;

    // A byte arriving while the register is full is dropped unless the
    // transmitter drains the old one in the same cycle.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            hold_q      <= '0;
            hold_full_q <= 1'b0;
        end else if (rx_valid && (!hold_full_q || tx_start)) begin
            hold_q      <= rx_data;
            hold_full_q <= 1'b1;
        end else if (tx_start) begin
            hold_full_q <= 1'b0;
        end
    end

    uart_tx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_tx (
        .clk_i   (CLK),
        .rst_ni  (RST_N),
        .start_i (tx_start),
        .data_i  (hold_q),
        .tx_o    (U_TX),
        .busy_o  (waitflg)
    );

    assign RED_N   = !rx_busy;
    assign GREEN_N = !waitflg;
    assign BLUE_N  = !frame_err;

endmodule

// File: tb/tb_uart_echo_top.sv
// tb/tb_uart_echo_top.sv - self-checking bench for uart_echo_top
module tb_uart_echo_top;
    localparam int B = 32;

    typedef struct {
        logic [7:0] data;
        logic       stop;
        logic       blue_n;
        int         gap;
    } vec_t;

    logic CLK = 1'b0;
    logic RST_N = 1'b0;
    logic U_RX = 1'b1;
    logic U_TX, RED_N, GREEN_N, BLUE_N;

    int   checks = 0;
    int   fails = 0;
    logic mon_en = 1'b0;
    logic [7:0] exp_q[$];
    int   n_pushed = 0;
    int   n_seen = 0;

    uart_echo_top #(.CLKS_PER_BIT(B)) dut (
        .CLK     (CLK),
        .RST_N   (RST_N),
        .U_RX    (U_RX),
        .U_TX    (U_TX),
        .RED_N   (RED_N),
        .GREEN_N (GREEN_N),
        .BLUE_N  (BLUE_N)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic check_range(input string name, input int act, input int lo, input int hi);
        checks++;
        if (act < lo || act > hi) begin
            fails++;
            $display("FAIL %s actual=%0d required=%0d..%0d", name, act, lo, hi);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic drive_bit(input logic v);
        U_RX = v;
        idle(B);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(b[i]);
        drive_bit(stop);
        U_RX = 1'b1;
    endtask

    task automatic push(input logic [7:0] b);
        exp_q.push_back(b);
        n_pushed++;
    endtask

    task automatic wait_quiet();
        int q;
        q = 0;
        for (int k = 0; k < 30 * B && q < 4; k++) begin
            @(posedge CLK);
            #1;
            if (!dut.waitflg && RED_N && !dut.hold_full_q) q++;
            else q = 0;
        end
        check("quiet_reached", int'(q >= 4), 1);
    endtask

    // Decodes every frame seen on U_TX at bit mid-points and scores it
    // against the queue of bytes the bench expects to be echoed.
    initial begin : tx_monitor
        logic [7:0] b;
        forever begin
            @(negedge U_TX);
            if (mon_en && RST_N) begin
                idle(B / 2);
                check("tx_start_bit", int'(U_TX), 0);
                for (int i = 0; i < 8; i++) begin
                    idle(B);
                    b[i] = U_TX;
                end
                idle(B);
                check("tx_stop_bit", int'(U_TX), 1);
                n_seen++;
                check("tx_echo_expected", int'(exp_q.size() != 0), 1);
                if (exp_q.size() != 0) check("tx_echo_byte", int'(b), int'(exp_q.pop_front()));
            end
        end
    end

    initial begin : watchdog
        #(400000 * 10);
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin : main
        vec_t tbl[7];
        int n, st, lows, hi;
        logic [7:0] rb;
        logic rs;

        tbl[0] = '{8'h96, 1'b1, 1'b1, 4};
        tbl[1] = '{8'h5A, 1'b0, 1'b0, B};
        tbl[2] = '{8'hC3, 1'b1, 1'b1, 4};
        tbl[3] = '{8'h01, 1'b1, 1'b1, 0};
        tbl[4] = '{8'h80, 1'b1, 1'b1, 4};
        tbl[5] = '{8'hE7, 1'b0, 1'b0, B};
        tbl[6] = '{8'h18, 1'b1, 1'b1, 4};

        // Reset state
        idle(3);
        check("rst_u_tx", int'(U_TX), 1);
        check("rst_red_n", int'(RED_N), 1);
        check("rst_green_n", int'(GREEN_N), 1);
        check("rst_blue_n", int'(BLUE_N), 1);
        check("rst_waitflg", int'(dut.waitflg), 0);
        check("rst_hold_full", int'(dut.hold_full_q), 0);
        RST_N = 1'b1;
        idle(20);
        mon_en = 1'b1;

        // Echo 0x55 and RX stop-bit edge to TX start-bit edge latency
        push(8'h55);
        send_frame(8'h55, 1'b1);
        n = B;
        for (int k = 0; k < 4 * B && U_TX; k++) begin
            @(posedge CLK);
            #1;
            n++;
        end
        check_range("rx_stop_to_tx_start", n, B - 4, B + 4);
        idle(2);
        check("tx_busy_waitflg", int'(dut.waitflg), 1);
        check("tx_busy_green_n", int'(GREEN_N), 0);
        wait_quiet();
        check("echo55_blue_n", int'(BLUE_N), 1);
        check("echo55_waitflg_fell", int'(dut.waitflg), 0);

        // 0x00 then 0xFF back-to-back: second leaves holding register right after first stop
        push(8'h00);
        push(8'hFF);
        st = 0;
        lows = 0;
        fork
            begin
                send_frame(8'h00, 1'b1);
                send_frame(8'hFF, 1'b1);
            end
            begin
                for (int k = 0; k < 25 * B && st < 3; k++) begin
                    @(posedge CLK);
                    #1;
                    case (st)
                        0: if (dut.waitflg) st = 1;
                        1: if (!dut.waitflg) begin st = 2; lows = 1; end
                        2: if (!dut.waitflg) lows++; else st = 3;
                        default: ;
                    endcase
                end
            end
        join
        check("b2b_handoff_seen", st, 3);
        check("b2b_waitflg_low_cycles", lows, 1);
        wait_quiet();

        // Framing error: no echo, BLUE lit; next good frame clears it
        hi = 0;
        fork
            begin
                send_frame(8'hA3, 1'b0);
                drive_bit(1'b1);
            end
            begin
                repeat (12 * B) begin
                    @(posedge CLK);
                    #1;
                    if (dut.waitflg) hi++;
                end
            end
        join
        check("ferr_tx_busy_cycles", hi, 0);
        check("ferr_blue_n", int'(BLUE_N), 0);
        check("ferr_red_n", int'(RED_N), 1);
        push(8'h3C);
        send_frame(8'h3C, 1'b1);
        idle(4);
        check("ferr_clear_blue_n", int'(BLUE_N), 1);
        wait_quiet();

        // Table-driven frames
        for (int i = 0; i < 7; i++) begin
            if (tbl[i].stop) push(tbl[i].data);
            send_frame(tbl[i].data, tbl[i].stop);
            idle(4);
            check($sformatf("table%0d_blue_n", i), int'(BLUE_N), int'(tbl[i].blue_n));
            idle(tbl[i].gap);
        end
        wait_quiet();

        // Glitch shorter than half a bit is rejected
        U_RX = 1'b0;
        idle(6);
        check("glitch_red_n_busy", int'(RED_N), 0);
        idle(2);
        U_RX = 1'b1;
        hi = 0;
        repeat (12 * B) begin
            @(posedge CLK);
            #1;
            if (dut.waitflg) hi++;
        end
        check("glitch_red_n_idle", int'(RED_N), 1);
        check("glitch_tx_busy_cycles", hi, 0);

        // Reset during TX data bit 4
        mon_en = 1'b0;
        send_frame(8'h00, 1'b1);
        idle(5 * B + B / 2);
        check("rst_mid_pre_waitflg", int'(dut.waitflg), 1);
        check("rst_mid_pre_u_tx", int'(U_TX), 0);
        #2;
        RST_N = 1'b0;
        #2;
        check("rst_mid_u_tx", int'(U_TX), 1);
        check("rst_mid_waitflg", int'(dut.waitflg), 0);
        check("rst_mid_red_n", int'(RED_N), 1);
        check("rst_mid_green_n", int'(GREEN_N), 1);
        check("rst_mid_blue_n", int'(BLUE_N), 1);
        check("rst_mid_hold_full", int'(dut.hold_full_q), 0);
        idle(3);
        RST_N = 1'b1;
        idle(12 * B);
        mon_en = 1'b1;
        push(8'h55);
        send_frame(8'h55, 1'b1);
        wait_quiet();

        // Randomized frames against the reference queue
        for (int i = 0; i < 12; i++) begin
            rb = 8'($urandom_range(0, 255));
            rs = ($urandom_range(0, 4) != 0);
            if (rs) push(rb);
            send_frame(rb, rs);
            idle(4);
            check("rand_blue_n", int'(BLUE_N), int'(rs));
            idle(rs ? int'($urandom_range(0, B)) : B);
        end
        wait_quiet();

        check("pending_echoes", exp_q.size(), 0);
        check("echo_count", n_seen, n_pushed);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
